// File: rtl/mux2_rr_arbiter_if.sv
// Two-stream-in, one-stream-out handshake bundle plus the mux select.
// master = stream producers / consumer side, slave = the arbiter.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;
  logic             in2_valid;
  logic [WIDTH-1:0] in2_data;
  logic             in2_last;
  logic             in2_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             sel;

  modport master (
    output in1_valid, in1_data, in1_last, in2_valid, in2_data, in2_last, out_ready,
    input  in1_ready, in2_ready, out_valid, out_data, out_last, sel
  );

  modport slave (
    input  in1_valid, in1_data, in1_last, in2_valid, in2_data, in2_last, out_ready,
    output in1_ready, in2_ready, out_valid, out_data, out_last, sel
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Packet-aware two-input round-robin arbiter with a registered output stage.
// sel drives the 2:1 mux select (0 = stream 1, 1 = stream 2).
module mux2_rr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LOCK_EN = 1
) (
  input logic             clk,
  input logic             rst,
  mux2_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT1 = 2'd1, GNT2 = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;      // 0 = stream 1 wins the next tie
  logic             sel_q, sel_d;
  logic             out_valid_q;
  logic             out_last_q;
  logic [WIDTH-1:0] out_data_q;

  logic             out_free;
  logic             rdy1, rdy2;
  logic             acc1, acc2;
  logic             last1, last2;

  // Output register can take a beat when empty or draining this cycle.
  assign out_free = ~out_valid_q | bus.out_ready;
  assign acc1     = bus.in1_valid & rdy1;
  assign acc2     = bus.in2_valid & rdy2;
  // Without packet lock every beat closes its own packet.
  assign last1    = (LOCK_EN != 0) ? bus.in1_last : 1'b1;
  assign last2    = (LOCK_EN != 0) ? bus.in2_last : 1'b1;

  // State, priority pointer and mux select registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  // Arbitration in IDLE; hold the grant until the packet's last beat is taken.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (bus.in1_valid && bus.in2_valid) state_d = ptr_q ? GNT2 : GNT1;
        else if (bus.in1_valid)             state_d = GNT1;
        else if (bus.in2_valid)             state_d = GNT2;
        if (state_d == GNT1)      sel_d = 1'b0;
        else if (state_d == GNT2) sel_d = 1'b1;
      end
      GNT1: begin
        if (acc1 && last1) begin
          state_d = IDLE;
          ptr_d   = 1'b1;
        end
      end
      GNT2: begin
        if (acc2 && last2) begin
          state_d = IDLE;
          ptr_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the granted stream sees ready, gated by output-register space.
  always_comb begin
    rdy1 = 1'b0;
    rdy2 = 1'b0;
    case (state_q)
      GNT1:    rdy1 = out_free;
      GNT2:    rdy2 = out_free;
      default: ;
    endcase
  end

  // Output stage: load on accept, otherwise clear valid once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (acc1) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in1_data;
      out_last_q  <= last1;
    end else if (acc2) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in2_data;
      out_last_q  <= last2;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in1_ready = rdy1;
  assign bus.in2_ready = rdy2;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.sel       = sel_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a packet-locked instance (ifa) and a
// per-beat instance (ifb). Inputs change on negedge; everything is observed
// 1 time unit after the negedge, where it is stable until the next posedge.
module tb_mux2_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.WIDTH(8)) ifa ();
  mux2_rr_arbiter_if #(.WIDTH(8)) ifb ();

  mux2_rr_arbiter #(.WIDTH(8), .LOCK_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux2_rr_arbiter #(.WIDTH(8), .LOCK_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // source queues: {last, data}
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [8:0] outq[$];
  logic       selq[$];
  int         cycq[$];
  logic [8:0] bq[$];
  logic       en1  = 1'b1;
  logic       ordy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ifa.in1_valid = en1 && (q1.size() > 0);
    ifa.in1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    ifa.in1_last  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
    ifa.in2_valid = (q2.size() > 0);
    ifa.in2_data  = (q2.size() > 0) ? q2[0][7:0] : 8'h00;
    ifa.in2_last  = (q2.size() > 0) ? q2[0][8]   : 1'b0;
    ifa.out_ready = ordy;
    #1;
    cyc++;
    if (ifa.in1_valid && ifa.in1_ready) void'(q1.pop_front());
    if (ifa.in2_valid && ifa.in2_ready) void'(q2.pop_front());
    if (ifa.out_valid && ifa.out_ready) begin
      outq.push_back({ifa.out_last, ifa.out_data});
      selq.push_back(ifa.sel);
      cycq.push_back(cyc);
    end
    if (ifb.out_valid && ifb.out_ready) bq.push_back({ifb.out_last, ifb.out_data});
  endtask

  task automatic run_until_out(input int n, input int budget);
    for (int i = 0; i < budget && outq.size() < n; i++) step();
    chk("out_count", outq.size(), n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] exp_rr[8];
    logic       exp_sel[8];
    logic [8:0] exp_lk[5];
    logic [8:0] exp_rs[3];
    logic       saw_rdy2;
    int         hold;

    ifa.in1_valid = 0; ifa.in1_data = 0; ifa.in1_last = 0;
    ifa.in2_valid = 0; ifa.in2_data = 0; ifa.in2_last = 0; ifa.out_ready = 1;
    ifb.in1_valid = 0; ifb.in1_data = 0; ifb.in1_last = 0;
    ifb.in2_valid = 0; ifb.in2_data = 0; ifb.in2_last = 0; ifb.out_ready = 1;

    // ---- reset defaults, then lone in2 request
    step(); step();
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_data",  ifa.out_data,  0);
    chk("rst_out_last",  ifa.out_last,  0);
    chk("rst_sel",       ifa.sel,       0);
    chk("rst_in1_ready", ifa.in1_ready, 0);
    chk("rst_in2_ready", ifa.in2_ready, 0);
    rst = 1'b0;
    q2.push_back({1'b1, 8'hC3});
    step();
    chk("idle_in2_ready", ifa.in2_ready, 0);
    chk("idle_sel",       ifa.sel,       0);
    step();
    chk("gnt2_sel",       ifa.sel,       1);
    chk("gnt2_in2_ready", ifa.in2_ready, 1);
    step();
    chk("first_out_valid", ifa.out_valid, 1);
    chk("first_out_data",  ifa.out_data,  8'hC3);
    chk("first_out_last",  ifa.out_last,  1);
    step();
    chk("drained_valid",   ifa.out_valid, 0);

    // ---- round robin with 2-beat packets
    outq.delete(); selq.delete(); cycq.delete();
    exp_rr  = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1};
    exp_sel = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 2; k++) begin
      q1.push_back(9'h0A0); q1.push_back(9'h1A1);
      q2.push_back(9'h0B0); q2.push_back(9'h1B1);
    end
    run_until_out(8, 40);
    for (int i = 0; i < 8; i++) begin
      if (i < outq.size()) begin
        chk($sformatf("rr_beat%0d", i), outq[i], exp_rr[i]);
        chk($sformatf("rr_sel%0d", i),  selq[i], exp_sel[i]);
      end
    end
    if (outq.size() >= 3) begin
      chk("rr_gap_in_pkt",  cycq[1] - cycq[0], 1);
      chk("rr_gap_bubble",  cycq[2] - cycq[1], 2);
    end

    // ---- packet lock: in1 stalls mid-packet while in2 waits
    outq.delete();
    exp_lk = '{9'h031, 9'h032, 9'h033, 9'h134, 9'h141};
    q1.push_back(9'h031); q1.push_back(9'h032); q1.push_back(9'h033); q1.push_back(9'h134);
    q2.push_back(9'h141);
    saw_rdy2 = 1'b0;
    hold = 0;
    for (int i = 0; i < 30 && outq.size() < 5; i++) begin
      en1 = !((q1.size() > 0) && (q1[0][7:0] == 8'h33) && (hold < 2));
      if (!en1) hold++;
      step();
      if (ifa.in2_ready && (q1.size() > 0)) saw_rdy2 = 1'b1;
    end
    en1 = 1'b1;
    chk("lock_out_count", outq.size(), 5);
    chk("lock_in2_ready", saw_rdy2, 0);
    chk("lock_hold_cycles", hold, 2);
    for (int i = 0; i < 5; i++)
      if (i < outq.size()) chk($sformatf("lock_beat%0d", i), outq[i], exp_lk[i]);

    // ---- backpressure with 0x5A pending
    q1.push_back(9'h05A); q1.push_back(9'h15B);
    step();
    step();
    chk("bp_accept_5a", q1.size(), 1);
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold_data%0d", i), ifa.out_data, 8'h5A);
      chk($sformatf("bp_hold_vld%0d", i),  ifa.out_valid, 1);
      chk($sformatf("bp_in1_rdy%0d", i),   ifa.in1_ready, 0);
    end
    ordy = 1'b1;
    step();
    chk("bp_release_rdy",  ifa.in1_ready, 1);
    chk("bp_release_data", ifa.out_data, 8'h5A);
    step();
    chk("bp_b2b_valid", ifa.out_valid, 1);
    chk("bp_b2b_data",  ifa.out_data,  8'h5B);
    step();
    chk("bp_done_valid", ifa.out_valid, 0);

    // ---- reset mid-packet on a 4-beat in2 packet
    q2.push_back(9'h061); q2.push_back(9'h062); q2.push_back(9'h063); q2.push_back(9'h164);
    for (int i = 0; i < 20 && q2.size() > 2; i++) step();
    chk("mid_two_taken", q2.size(), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", ifa.out_valid, 0);
    chk("mid_rst_data",  ifa.out_data,  0);
    chk("mid_rst_sel",   ifa.sel,       0);
    chk("mid_rst_rdy2",  ifa.in2_ready, 0);
    outq.delete();
    q1.push_back(9'h171);
    step();
    rst = 1'b0;
    exp_rs = '{9'h171, 9'h063, 9'h164};
    run_until_out(3, 30);
    for (int i = 0; i < 3; i++)
      if (i < outq.size()) chk($sformatf("mid_beat%0d", i), outq[i], exp_rs[i]);

    // ---- per-beat arbitration instance
    bq.delete();
    @(negedge clk);
    ifb.in1_valid = 1; ifb.in1_data = 8'h11; ifb.in1_last = 0;
    ifb.in2_valid = 1; ifb.in2_data = 8'h22; ifb.in2_last = 0;
    ifb.out_ready = 1;
    for (int i = 0; i < 12; i++) step();
    chk("nolock_count_ge4", (bq.size() >= 4), 1);
    for (int i = 0; i < 4; i++)
      if (i < bq.size())
        chk($sformatf("nolock_beat%0d", i), bq[i], (i % 2 == 0) ? 9'h111 : 9'h122);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Two-input, packet-aware round-robin arbiter that feeds the 2:1 library mux stage. It selects one of two valid/ready streams and drives the mux select `sel`. It also forwards the granted stream's beats through a single registered output stage. Used wherever two producers share one downstream datapath, with `sel` tied directly to the mux `s` pin.

Parameters:
WIDTH, 8, data width of each input stream and of the output stream.
LOCK_EN, 1, 1 = hold grant until a beat with last=1 is accepted; 0 = every beat is treated as last (per-beat arbitration).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in1_valid  input  1  stream 1 beat valid.
in1_data  input  WIDTH  stream 1 payload.
in1_last  input  1  stream 1 end-of-packet marker.
in1_ready  output  1  stream 1 beat accepted when valid & ready.
in2_valid  input  1  stream 2 beat valid.
in2_data  input  WIDTH  stream 2 payload.
in2_last  input  1  stream 2 end-of-packet marker.
in2_ready  output  1  stream 2 accept.
out_valid  output  1  registered output beat valid.
out_data  output  WIDTH  registered output payload.
out_last  output  1  registered output end-of-packet.
out_ready  input  1  downstream accept.
sel  output  1  registered mux select; 0 = stream 1 (mux d1), 1 = stream 2 (mux d2).

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-high (`clk`, `rst`).
- Reset values: out_valid=0, out_data=0, out_last=0, sel=0, state=IDLE, priority pointer = stream 1. in1_ready and in2_ready are 0 while in IDLE.
- Reset mid-packet: async clear to the values above. The partial packet is dropped and no beat is emitted after rst deasserts until re-arbitration.
- Output register frees when `out_free = ~out_valid | out_ready`.
- States: IDLE, GNT1, GNT2.
- IDLE, no valid: stay in IDLE.
- IDLE, exactly one input valid: go to that input's GNTx next cycle.
- IDLE, both inputs valid: go to the GNT state named by the priority pointer.
- `sel` updates on entry to GNT1 (0) / GNT2 (1) and holds its value through IDLE.
- GNTx: inx_ready = out_free; the other input's ready is 0.
- On inx accept: the output register loads data/last and out_valid=1. out_last = inx_last when LOCK_EN=1, and 1 when LOCK_EN=0.
- Accept with effective last=1: return to IDLE and set the priority pointer to the other input.
- Accept with last=0: stay in GNTx.
- GNTx with inx_valid=0: stay in GNTx (grant is held; no timeout).
- Output stage: if out_valid & out_ready and there is no new load, out_valid goes to 0. A simultaneous drain and load is a back-to-back transfer with out_valid held at 1.
- Latency: input accept to out_valid is 1 cycle. Each packet costs one IDLE arbitration cycle, so peak throughput is 1 beat/cycle within a packet.
- Data never changes while out_valid=1 & out_ready=0 (stall hold).
- No beat is lost or duplicated. Per-stream beat order is preserved, and packets from the two streams never interleave while LOCK_EN=1.
- The priority pointer updates only on a completed packet, never on an idle grant.

Test Plan:
- Reset defaults: assert rst mid-run -> all outputs 0 and sel=0 immediately (async). With in2_valid=1 after release -> GNT2 entered 1 cycle later, sel=1, first out_valid 1 cycle after in2 accept.
- Round-robin fairness: both streams continuously valid, 2-beat packets (1:A0,A1; 2:B0,B1), out_ready=1 -> output A0,A1,B0,B1,A0,... with a one-cycle bubble between packets and sel toggling 0,1,0.
- Packet lock: in1 sends a 4-beat packet with in1_valid low on beat 3 for 2 cycles while in2 is valid -> in2_ready stays 0 throughout, and output is the 4 in1 beats contiguous, then in2.
- Backpressure: out_ready=0 for 3 cycles while in GNT1 with data 0x5A pending -> out_data holds 0x5A, in1_ready=0. Then out_ready=1 -> next beat loads in the same cycle the 0x5A beat drains.
- LOCK_EN=0: both streams valid, single-beat data, in1_last=0 -> output alternates in1/in2 beats, out_last=1 on every beat.
- Reset mid-packet: rst pulsed after beat 2 of a 4-beat in2 packet -> no further in2 beats emitted before re-arbitration. Priority pointer resets to stream 1, so in1 wins the next tie.
